mem_access_unit: RTL and testbench

Memory-stage access controller sitting between the EX/MEM pipeline register and the word-addressed data memory. It converts byte addresses to word indices and performs byte/halfword load extraction. Sub-word stores become a two-cycle read-modify-write, during which the block stalls the upstream pipeline. Misaligned or illegal accesses are flagged and suppressed.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_lane_align.sv | 38 +++
 rtl/mem_access_unit.sv | 142 ++++++++++++++
 tb/tb_mem_access_unit.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage access controller: op encodings, FSM states, default depth.
package mem_pkg;

  localparam int DM_DEPTH_DEFAULT = 128;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } mem_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MERGE = 1'b1
  } mau_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Lane extract (sign/zero-extended loads) and lane merge (sub-word stores); only built with MEM_SUBWORD_EN.
// Latency: purely combinational.
// Backpressure: none; the caller owns sequencing.
`ifdef MEM_SUBWORD_EN
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rd_word,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Little-endian lanes: byte k sits at bits 8k+7:8k.
  assign sel_byte = rd_word[{byte_off, 3'b000} +: 8];
  assign sel_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data  = rd_word;
    merge_word = rd_word;
    case (mem_op_e'(op))
      OP_LH:   load_data = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  load_data = {16'h0000, sel_half};
      OP_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  load_data = {24'h000000, sel_byte};
      OP_SB:   merge_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
      OP_SH:   merge_word[{byte_off[1], 4'b0000} +: 16] = wdata;
      default: ;
    endcase
  end

endmodule
`endif

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: byte address to word index, load lanes, sub-word store read-modify-write.
// Latency: loads and SW finish the same cycle; SB/SH read, stall one cycle, write on the posedge ending MERGE.
// Backpressure: stall freezes upstream for SB/SH; sub-word ops exist only with `define MEM_SUBWORD_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DM_DEPTH = DM_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic [31:0] dm_address,
  output logic [31:0] dm_write_data,
  output logic        dm_memwrite,
  output logic        dm_memread,
  input  logic [31:0] dm_read_data
);

  localparam int AW   = $clog2(DM_DEPTH);
  localparam int PADW = 32 - AW;

  mem_op_e       op;
  logic [AW-1:0] word_idx;
  logic [31:0]   idx_ext;
  logic          op_word;
  logic          legal;
  logic          unused_addr;

  assign op       = mem_op_e'(req_op);
  // Upper address bits are dropped so accesses wrap modulo the memory depth.
  assign word_idx = req_addr[AW+1:2];
  assign idx_ext  = {{PADW{1'b0}}, word_idx};
  assign op_word  = (op == OP_LW) || (op == OP_SW);
  assign unused_addr = ^req_addr[31:AW+2];

`ifdef MEM_SUBWORD_EN
  mau_state_e    state;
  mau_state_e    state_nxt;
  logic [AW-1:0] cap_idx;
  logic [31:0]   cap_word;
  logic [31:0]   lane_rdata;
  logic [31:0]   lane_merge;
  logic          cap_en;
  logic          op_half;

  assign op_half = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  assign legal   = op_word ? (req_addr[1:0] == 2'b00) : (op_half ? !req_addr[0] : 1'b1);

  mem_lane_align u_lane_align (
    .op         (req_op),
    .byte_off   (req_addr[1:0]),
    .rd_word    (dm_read_data),
    .wdata      (req_wdata[15:0]),
    .load_data  (lane_rdata),
    .merge_word (lane_merge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cap_idx  <= '0;
      cap_word <= '0;
    end else begin
      state <= state_nxt;
      if (cap_en) begin
        cap_idx  <= word_idx;
        cap_word <= lane_merge;
      end
    end
  end
`else
  assign legal = op_word && (req_addr[1:0] == 2'b00);
`endif

  always_comb begin
    stall         = 1'b0;
    done          = 1'b0;
    fault         = 1'b0;
    rdata         = '0;
    dm_address    = '0;
    dm_write_data = '0;
    dm_memwrite   = 1'b0;
    dm_memread    = 1'b0;
`ifdef MEM_SUBWORD_EN
    state_nxt     = state;
    cap_en        = 1'b0;
`endif
    // Outputs are held quiet while reset is asserted, which also aborts an in-flight merge write.
    if (rst_n) begin
`ifdef MEM_SUBWORD_EN
      if (state == ST_MERGE) begin
        dm_address    = {{PADW{1'b0}}, cap_idx};
        dm_write_data = cap_word;
        dm_memwrite   = 1'b1;
        done          = 1'b1;
        state_nxt     = ST_IDLE;
      end else
`endif
      if (req_valid) begin
        if (!legal) begin
          fault = 1'b1;
        end else begin
          dm_address = idx_ext;
          case (op)
            OP_SW: begin
              dm_memwrite   = 1'b1;
              dm_write_data = req_wdata;
              done          = 1'b1;
            end
`ifdef MEM_SUBWORD_EN
            OP_SB, OP_SH: begin
              dm_memread = 1'b1;
              stall      = 1'b1;
              cap_en     = 1'b1;
              state_nxt  = ST_MERGE;
            end
            default: begin
              dm_memread = 1'b1;
              rdata      = lane_rdata;
              done       = 1'b1;
            end
`else
            default: begin
              dm_memread = 1'b1;
              rdata      = dm_read_data;
              done       = 1'b1;
            end
`endif
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array reference memory model checked every cycle, plus literal spot checks.
// Follows MEM_SUBWORD_EN the same way the design does.
module tb_mem_access_unit;

  localparam int DEPTH = 128;
  localparam int NBYTES = DEPTH * 4;
  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                         LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        stall, done, fault, dm_memwrite, dm_memread;
  logic [31:0] rdata, dm_address, dm_write_data, dm_read_data;

  logic [31:0] dmem [DEPTH];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DM_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .stall         (stall),
    .done          (done),
    .fault         (fault),
    .rdata         (rdata),
    .dm_address    (dm_address),
    .dm_write_data (dm_write_data),
    .dm_memwrite   (dm_memwrite),
    .dm_memread    (dm_memread),
    .dm_read_data  (dm_read_data)
  );

  // Data memory the DUT drives.
  assign dm_read_data = dmem[dm_address[6:0]];
  always @(posedge clk) if (dm_memwrite) dmem[dm_address[6:0]] <= dm_write_data;

  // ---------------- reference model: architectural byte memory ----------------
  byte unsigned ref_mem [NBYTES];
  logic        pend = 1'b0;
  logic [2:0]  pend_op = 3'd0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] pend_wdata = 32'h0;

  function automatic int unsigned op_size(input logic [2:0] op);
    case (op)
      LW, SW:      return 4;
      LH, LHU, SH: return 2;
      default:     return 1;
    endcase
  endfunction

  function automatic logic op_legal(input logic [2:0] op, input logic [31:0] addr);
    int unsigned sz = op_size(op);
`ifndef MEM_SUBWORD_EN
    if (sz != 4) return 1'b0;
`endif
    return (addr % sz) == 0;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] op, input logic [31:0] addr);
    int unsigned sz = op_size(op);
    int unsigned base = addr % NBYTES;
    longint v = 0;
    for (int i = 0; i < 4; i++)
      if (i < sz) v += longint'(ref_mem[base + i]) << (8 * i);
    if ((op == LB || op == LH) && v >= (longint'(1) << (8 * sz - 1)))
      v -= (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  function automatic logic [31:0] merged_word(input logic [2:0] op, input logic [31:0] addr,
                                               input logic [31:0] wdata);
    int unsigned sz = op_size(op);
    int unsigned base = addr % NBYTES;
    int unsigned wbase = base - (base % 4);
    byte unsigned b [4];
    for (int i = 0; i < 4; i++) b[i] = ref_mem[wbase + i];
    for (int i = 0; i < 4; i++)
      if (i < sz) b[(base % 4) + i] = wdata[8 * i +: 8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // Architectural commit of a store: SW immediately, SB/SH once their second cycle completes.
  logic        st_en;
  int unsigned st_sz;
  int unsigned st_base;
  logic [31:0] st_wdata;
  always_comb begin
    st_en    = 1'b0;
    st_sz    = op_size(pend_op);
    st_base  = pend_addr % NBYTES;
    st_wdata = pend_wdata;
    if (pend) begin
      st_en = 1'b1;
    end else if (req_valid && req_op == SW && op_legal(req_op, req_addr)) begin
      st_en    = 1'b1;
      st_sz    = 4;
      st_base  = req_addr % NBYTES;
      st_wdata = req_wdata;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
    end else begin
      if (st_en)
        for (int i = 0; i < 4; i++)
          if (i < st_sz) ref_mem[st_base + i] <= st_wdata[8 * i +: 8];
      if (pend) begin
        pend <= 1'b0;
      end else if (req_valid && (req_op == SB || req_op == SH) && op_legal(req_op, req_addr)) begin
        pend       <= 1'b1;
        pend_op    <= req_op;
        pend_addr  <= req_addr;
        pend_wdata <= req_wdata;
      end
    end
  end

  typedef struct packed {
    logic        chk_addr;
    logic        chk_wdata;
    logic        stall;
    logic        done;
    logic        fault;
    logic        mw;
    logic        mr;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    e.chk_addr  = 1'b1;
    e.chk_wdata = 1'b1;
    if (!rst_n) return e;
    if (pend) begin
      e.mw    = 1'b1;
      e.done  = 1'b1;
      e.addr  = (pend_addr % NBYTES) / 4;
      e.wdata = merged_word(pend_op, pend_addr, pend_wdata);
      return e;
    end
    if (!req_valid) return e;
    if (!op_legal(req_op, req_addr)) begin
      e.fault     = 1'b1;
      e.chk_addr  = 1'b0;
      e.chk_wdata = 1'b0;
      return e;
    end
    e.addr = (req_addr % NBYTES) / 4;
    if (req_op <= LBU) begin
      e.mr        = 1'b1;
      e.done      = 1'b1;
      e.rdata     = load_val(req_op, req_addr);
      e.chk_wdata = 1'b0;
    end else if (req_op == SW) begin
      e.mw    = 1'b1;
      e.done  = 1'b1;
      e.wdata = req_wdata;
    end else begin
      e.mr        = 1'b1;
      e.stall     = 1'b1;
      e.chk_wdata = 1'b0;
    end
    return e;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h at t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic compare_cycle();
    exp_t e;
    e = model_out();
    chk1("stall", stall, e.stall);
    chk1("done", done, e.done);
    chk1("fault", fault, e.fault);
    chk1("dm_memwrite", dm_memwrite, e.mw);
    chk1("dm_memread", dm_memread, e.mr);
    chk("rdata", rdata, e.rdata);
    if (e.chk_addr) chk("dm_address", dm_address, e.addr);
    if (e.chk_wdata) chk("dm_write_data", dm_write_data, e.wdata);
  endtask

  initial forever begin
    @(negedge clk);
    compare_cycle();
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    req_valid = v;
    req_op    = op;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, LW, 32'h0, 32'h0);
  endtask

  task automatic load_expect(input string name, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] expv);
    drive(1'b1, op, a, 32'h0);
    chk(name, rdata, expv);
    chk1({name, "_done"}, done, 1'b1);
  endtask

`ifdef MEM_SUBWORD_EN
  // Sub-word store: request held through the stall cycle, as a frozen EX/MEM would.
  task automatic sub_store(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] merged);
    drive(1'b1, op, a, d);
    chk1({name, "_stall"}, stall, 1'b1);
    chk1({name, "_read"}, dm_memread, 1'b1);
    drive(1'b1, op, a, d);
    chk1({name, "_merge_stall"}, stall, 1'b0);
    chk1({name, "_merge_wr"}, dm_memwrite, 1'b1);
    chk({name, "_merge_word"}, dm_write_data, merged);
  endtask
`endif

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("reset_stall", stall, 1'b0);
    chk1("reset_done", done, 1'b0);
    chk("reset_addr", dm_address, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    drive(1'b1, SW, 32'h10, 32'hDEADBEEF);
    chk("sw_addr", dm_address, 32'd4);
    chk1("sw_done", done, 1'b1);
    load_expect("lw_10", LW, 32'h10, 32'hDEADBEEF);
    chk("lw_addr", dm_address, 32'd4);
    chk1("lw_stall", stall, 1'b0);

    drive(1'b1, SW, 32'h08, 32'h11223344);
    drive(1'b1, SW, 32'h20, 32'h80FF7F01);
    drive(1'b1, SW, 32'h204, 32'hCAFEF00D);
    chk("wrap_addr", dm_address, 32'd1);
    load_expect("lw_wrap", LW, 32'h4, 32'hCAFEF00D);

    drive(1'b1, LW, 32'h22, 32'h0);
    chk1("lw_mis_fault", fault, 1'b1);
    chk1("lw_mis_read", dm_memread, 1'b0);
    idle();

`ifdef MEM_SUBWORD_EN
    load_expect("lb_23", LB, 32'h23, 32'hFFFFFF80);
    load_expect("lbu_23", LBU, 32'h23, 32'h00000080);
    load_expect("lh_22", LH, 32'h22, 32'hFFFF80FF);
    load_expect("lhu_20", LHU, 32'h20, 32'h00007F01);

    drive(1'b1, SW, 32'h20, 32'h11223344);
    sub_store("sb_21", SB, 32'h21, 32'h000000AA, 32'h1122AA44);
    sub_store("sh_22", SH, 32'h22, 32'h0000BEEF, 32'hBEEFAA44);
    load_expect("lw_after_sh", LW, 32'h20, 32'hBEEFAA44);
    sub_store("sb_20", SB, 32'h20, 32'h00000055, 32'hBEEFAA55);
    sub_store("sb_23", SB, 32'h23, 32'h00000066, 32'h66EFAA55);
    chk("dmem_8", dmem[8], 32'h66EFAA55);

    drive(1'b1, SH, 32'h21, 32'h00001234);
    chk1("sh_mis_fault", fault, 1'b1);
    chk1("sh_mis_wr", dm_memwrite, 1'b0);
    chk1("sh_mis_stall", stall, 1'b0);
    load_expect("lw_unchanged", LW, 32'h20, 32'h66EFAA55);

    // Reset while the merge write is pending must leave the word untouched.
    drive(1'b1, SB, 32'h08, 32'h000000AA);
    chk1("rst_sb_stall", stall, 1'b1);
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk1("rst_merge_wr", dm_memwrite, 1'b0);
    chk1("rst_merge_done", done, 1'b0);
    chk("rst_merge_wdata", dm_write_data, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    load_expect("lw_after_rst", LW, 32'h08, 32'h11223344);
    chk("dmem_2", dmem[2], 32'h11223344);
`else
    drive(1'b1, LB, 32'h204, 32'h0);
    chk1("lb_unsup_fault", fault, 1'b1);
    chk1("lb_unsup_read", dm_memread, 1'b0);
    drive(1'b1, SH, 32'h20, 32'h0000BEEF);
    chk1("sh_unsup_fault", fault, 1'b1);
    chk1("sh_unsup_stall", stall, 1'b0);
    drive(1'b1, SB, 32'h21, 32'h000000AA);
    chk1("sb_unsup_wr", dm_memwrite, 1'b0);
    load_expect("lw_unchanged", LW, 32'h20, 32'h80FF7F01);
    chk("dmem_8", dmem[8], 32'h80FF7F01);
`endif

    idle();
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
